// File: rtl/i281_trace_pkg.sv
// Shared FSM type, field widths and entry-width helper for the i281 trace buffer.
// Defining I281_TRACE_TIMESTAMP_EN adds a 16-bit timestamp field to every entry.
package i281_trace_pkg;

  localparam int INSTR_W = 5;
  localparam int STATE_W = 6;
  localparam int FLAGS_W = 4;
  localparam int TS_W    = 16;

  localparam logic [STATE_W-1:0] IF_STATE = '0;

`ifdef I281_TRACE_TIMESTAMP_EN
  localparam int TS_FIELD_W = TS_W;
`else
  localparam int TS_FIELD_W = 0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } trace_state_t;

  // Entry layout, MSB to LSB: [timestamp], instr, state, regs, flags.
  function automatic int entry_width(input int num_regs, input int data_w);
    return TS_FIELD_W + INSTR_W + STATE_W + num_regs * data_w + FLAGS_W;
  endfunction

endpackage

// File: rtl/i281_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// Contents are never reset; a read of the address being written returns the old data.
module i281_trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/i281_trace_buffer.sv
// Circular execution-trace recorder for the i281 CPU with instruction-match trigger.
// Optional timestamp field: define I281_TRACE_TIMESTAMP_EN.
module i281_trace_buffer
  import i281_trace_pkg::*;
#(
  parameter int NUM_REGS     = 4,
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int POST_TRIG    = 4,
  parameter int CAPTURE_MODE = 0
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      run,
  input  logic [INSTR_W-1:0]                        instr,
  input  logic [STATE_W-1:0]                        state,
  input  logic [NUM_REGS*DATA_W-1:0]                regs,
  input  logic [FLAGS_W-1:0]                        flags,
  input  logic                                      arm,
  input  logic                                      stop,
  input  logic                                      force_trig,
  input  logic [INSTR_W-1:0]                        trig_instr,
  input  logic [$clog2(DEPTH)-1:0]                  rd_addr,
  output logic [entry_width(NUM_REGS, DATA_W)-1:0]  rd_data,
  output logic                                      rd_valid,
  output logic [$clog2(DEPTH):0]                    count,
  output logic                                      busy,
  output logic                                      done
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = entry_width(NUM_REGS, DATA_W);

  localparam logic [AW:0]   FULL      = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POST_LOAD = AW'(POST_TRIG);
  localparam logic [AW-1:0] POST_ONE  = AW'(1);

  // With no post-trigger window the trigger entry is the last one captured.
  localparam trace_state_t TRIG_NEXT = (POST_TRIG == 0) ? ST_DONE : ST_POST;

  trace_state_t        fsm_q, fsm_d;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       post_cnt;
  logic                qual;
  logic                clear;
  logic                wr_en;
  logic                post_load;
  logic                post_dec;
  logic [ENTRY_W-1:0]  entry;
  logic [AW-1:0]       oldest;
  logic [AW-1:0]       phys_addr;
  logic [ENTRY_W-1:0]  ram_q;
  logic                rd_valid_q;

  assign qual = run && ((CAPTURE_MODE == 0) || (state == IF_STATE));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Priority is arm, then stop, then trigger; only ARMED and POST write.
  always_comb begin
    fsm_d     = fsm_q;
    clear     = 1'b0;
    wr_en     = 1'b0;
    post_load = 1'b0;
    post_dec  = 1'b0;
    if (arm) begin
      fsm_d = ST_ARMED;
      clear = 1'b1;
    end else if (stop) begin
      fsm_d = ST_IDLE;
    end else begin
      case (fsm_q)
        ST_ARMED: begin
          wr_en = qual;
          if (force_trig || (qual && (instr == trig_instr))) begin
            post_load = 1'b1;
            fsm_d     = TRIG_NEXT;
          end
        end
        ST_POST: begin
          if (qual) begin
            wr_en    = 1'b1;
            post_dec = 1'b1;
            if (post_cnt == POST_ONE) begin
              fsm_d = ST_DONE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count != FULL) begin
          count <= count + 1'b1;
        end
      end
      if (post_load) begin
        post_cnt <= POST_LOAD;
      end else if (post_dec) begin
        post_cnt <= post_cnt - 1'b1;
      end
    end
  end

`ifdef I281_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts <= '0;
    end else if (clear) begin
      ts <= '0;
    end else if ((fsm_q == ST_ARMED) || (fsm_q == ST_POST)) begin
      ts <= ts + 1'b1;
    end
  end

  assign entry = {ts, instr, state, regs, flags};
`else
  assign entry = {instr, state, regs, flags};
`endif

  // Once the buffer has wrapped, the slot about to be overwritten is the oldest.
  assign oldest    = (count == FULL) ? wr_ptr : '0;
  assign phys_addr = oldest + rd_addr;

  i281_trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (entry),
    .rd_addr (phys_addr),
    .rd_data (ram_q)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= ({1'b0, rd_addr} < count);
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? ram_q : '0;
  assign busy     = (fsm_q == ST_ARMED) || (fsm_q == ST_POST);
  assign done     = (fsm_q == ST_DONE);

endmodule

// File: tb/tb_i281_trace_buffer.sv
// Scoreboard bench for i281_trace_buffer: an every-cycle instance and an IF-only instance
// share stimulus and are checked against a history-log reference model.
module tb_i281_trace_buffer;
  import i281_trace_pkg::*;

  localparam int NREGS  = 4;
  localparam int DW     = 8;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int POST   = 3;
  localparam int EW     = entry_width(NREGS, DW);
  localparam int BASE_W = EW - TS_FIELD_W;
  localparam int HIST   = 4096;
  localparam int ST_LSB = FLAGS_W + NREGS * DW;

  localparam int M_IDLE  = 0;
  localparam int M_ARMED = 1;
  localparam int M_POST  = 2;
  localparam int M_DONE  = 3;

  localparam logic [4:0] TRIG = 5'd7;

  typedef struct {
    logic [EW-1:0] rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
  } exp_t;

  logic          clock      = 1'b0;
  logic          reset      = 1'b1;
  logic          run        = 1'b0;
  logic [4:0]    instr      = '0;
  logic [5:0]    state      = '0;
  logic [31:0]   regs       = '0;
  logic [3:0]    flags      = '0;
  logic          arm        = 1'b0;
  logic          stop       = 1'b0;
  logic          force_trig = 1'b0;
  logic [4:0]    trig_instr = TRIG;
  logic [AW-1:0] rd_addr    = '0;

  logic [EW-1:0] rd_data0, rd_data1;
  logic          rd_valid0, rd_valid1;
  logic [AW:0]   count0, count1;
  logic          busy0, busy1, done0, done1;

  int n_tests = 0;
  int n_fail  = 0;

  int mst [2];
  int post_left [2];
  int ts_m [2];
  int nwr [2];
  logic [EW-1:0] hist [2][HIST];

  exp_t exp_q0 [$];
  exp_t exp_q1 [$];

  logic [EW-1:0] last_snap;

  i281_trace_buffer #(
    .NUM_REGS(NREGS), .DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(POST), .CAPTURE_MODE(0)
  ) dut0 (
    .clock(clock), .reset(reset), .run(run), .instr(instr), .state(state), .regs(regs),
    .flags(flags), .arm(arm), .stop(stop), .force_trig(force_trig), .trig_instr(trig_instr),
    .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0), .count(count0),
    .busy(busy0), .done(done0)
  );

  i281_trace_buffer #(
    .NUM_REGS(NREGS), .DATA_W(DW), .DEPTH(DEPTH), .POST_TRIG(POST), .CAPTURE_MODE(1)
  ) dut1 (
    .clock(clock), .reset(reset), .run(run), .instr(instr), .state(state), .regs(regs),
    .flags(flags), .arm(arm), .stop(stop), .force_trig(force_trig), .trig_instr(trig_instr),
    .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1), .count(count1),
    .busy(busy1), .done(done1)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  function automatic logic [EW-1:0] makeEntry(input logic [4:0] i, input logic [5:0] s,
                                               input logic [31:0] r, input logic [3:0] f);
    logic [EW-1:0] e;
    e = '0;
    e[BASE_W-1:0] = {i, s, r, f};
    return e;
  endfunction

  function automatic logic [4:0] randInstr();
    logic [4:0] v;
    v = 5'($urandom_range(0, 30));
    if (v >= TRIG) v = v + 5'd1;
    return v;
  endfunction

  // Reference model: a log of every entry written since arm; the visible
  // window is simply its last DEPTH entries, oldest first.
  task automatic modelStep(input int m, input int cm, output exp_t e);
    bit q;
    bit was_active;
    int size;
    logic [EW-1:0] ent;
    q = run && (cm == 0 || state == 6'd0);
    size = (nwr[m] < DEPTH) ? nwr[m] : DEPTH;
    e.rd_valid = (int'(rd_addr) < size);
    e.rd_data  = e.rd_valid ? hist[m][nwr[m] - size + int'(rd_addr)] : '0;
    ent = makeEntry(instr, state, regs, flags);
`ifdef I281_TRACE_TIMESTAMP_EN
    ent[EW-1 -: TS_W] = ts_m[m][TS_W-1:0];
`endif
    was_active = (mst[m] == M_ARMED) || (mst[m] == M_POST);
    if (arm) begin
      mst[m] = M_ARMED;
      nwr[m] = 0;
      post_left[m] = 0;
      ts_m[m] = 0;
    end else begin
      if (was_active) ts_m[m] = (ts_m[m] + 1) % 65536;
      if (stop) begin
        mst[m] = M_IDLE;
      end else if (mst[m] == M_ARMED) begin
        if (q && nwr[m] < HIST) begin
          hist[m][nwr[m]] = ent;
          nwr[m]++;
        end
        if (force_trig || (q && instr == trig_instr)) begin
          post_left[m] = POST;
          mst[m] = (POST == 0) ? M_DONE : M_POST;
        end
      end else if (mst[m] == M_POST && q) begin
        if (nwr[m] < HIST) begin
          hist[m][nwr[m]] = ent;
          nwr[m]++;
        end
        post_left[m]--;
        if (post_left[m] == 0) mst[m] = M_DONE;
      end
    end
    size = (nwr[m] < DEPTH) ? nwr[m] : DEPTH;
    e.count = (AW+1)'(size);
    e.busy  = (mst[m] == M_ARMED) || (mst[m] == M_POST);
    e.done  = (mst[m] == M_DONE);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input bit r, input logic [4:0] i, input logic [5:0] s,
                               input bit a, input bit st, input bit ft, input logic [AW-1:0] ra);
    exp_t e0, e1;
    run = r; instr = i; state = s; arm = a; stop = st; force_trig = ft; rd_addr = ra;
    regs = $urandom;
    flags = 4'($urandom);
    last_snap = makeEntry(i, s, regs, flags);
    modelStep(0, 0, e0);
    modelStep(1, 1, e1);
    exp_q0.push_back(e0);
    exp_q1.push_back(e1);
    @(negedge clock);
  endtask

  task automatic applyReset();
    exp_t z;
    run = 0; arm = 0; stop = 0; force_trig = 0;
    #2 reset = 1'b0;
    #1;
    checkOutput("async_busy0",  64'(busy0),  64'(0));
    checkOutput("async_done0",  64'(done0),  64'(0));
    checkOutput("async_count0", 64'(count0), 64'(0));
    checkOutput("async_valid0", 64'(rd_valid0), 64'(0));
    checkOutput("async_busy1",  64'(busy1),  64'(0));
    checkOutput("async_count1", 64'(count1), 64'(0));
    for (int m = 0; m < 2; m++) begin
      mst[m] = M_IDLE; nwr[m] = 0; post_left[m] = 0; ts_m[m] = 0;
    end
    z.rd_data = '0; z.rd_valid = 1'b0; z.count = '0; z.busy = 1'b0; z.done = 1'b0;
    exp_q0.push_back(z);
    exp_q1.push_back(z);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic compareInst(input int m, input exp_t e, input logic [EW-1:0] d, input logic v,
                             input logic [AW:0] c, input logic b, input logic dn);
    checkOutput($sformatf("sb_rd_valid%0d", m), 64'(v),  64'(e.rd_valid));
    checkOutput($sformatf("sb_rd_data%0d", m),  64'(d),  64'(e.rd_data));
    checkOutput($sformatf("sb_count%0d", m),    64'(c),  64'(e.count));
    checkOutput($sformatf("sb_busy%0d", m),     64'(b),  64'(e.busy));
    checkOutput($sformatf("sb_done%0d", m),     64'(dn), 64'(e.done));
  endtask

  // Monitor: after every rising edge, score whatever the stimulus queued for it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q0.size() > 0) begin
        e = exp_q0.pop_front();
        compareInst(0, e, rd_data0, rd_valid0, count0, busy0, done0);
      end
      if (exp_q1.size() > 0) begin
        e = exp_q1.pop_front();
        compareInst(1, e, rd_data1, rd_valid1, count1, busy1, done1);
      end
    end
  end

  initial begin
    #1000000;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [EW-1:0] first_snap, trig_snap, post_snap;
    logic [5:0] seq [4];
    seq[0] = 6'd0; seq[1] = 6'd1; seq[2] = 6'd2; seq[3] = 6'd8;
    for (int m = 0; m < 2; m++) begin
      mst[m] = M_IDLE; nwr[m] = 0; post_left[m] = 0; ts_m[m] = 0;
    end

    #1 reset = 1'b0;
    #1;
    checkOutput("rst_busy0",  64'(busy0),  64'(0));
    checkOutput("rst_done0",  64'(done0),  64'(0));
    checkOutput("rst_count0", 64'(count0), 64'(0));
    checkOutput("rst_valid0", 64'(rd_valid0), 64'(0));
    checkOutput("rst_data0",  64'(rd_data0), 64'(0));
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Arm, five captures without a trigger, then read back.
    applyStimulus(0, randInstr(), 6'd0, 1, 0, 0, '0);
    first_snap = '0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, randInstr(), 6'($urandom_range(0, 3)), 0, 0, 0, '0);
      if (k == 0) first_snap = last_snap;
    end
    applyStimulus(0, randInstr(), 6'd0, 0, 0, 0, 3'd0);
    checkOutput("t1_count", 64'(count0), 64'(5));
    checkOutput("t1_busy",  64'(busy0),  64'(1));
    checkOutput("t1_valid0", 64'(rd_valid0), 64'(1));
    checkOutput("t1_first", 64'(rd_data0[BASE_W-1:0]), 64'(first_snap[BASE_W-1:0]));
    applyStimulus(0, randInstr(), 6'd0, 0, 0, 0, 3'd5);
    checkOutput("t1_valid5", 64'(rd_valid0), 64'(0));
    checkOutput("t1_data5",  64'(rd_data0),  64'(0));

    // Twenty captures, trigger on opcode 7, then three post-trigger captures.
    applyStimulus(0, randInstr(), 6'd0, 1, 0, 0, '0);
    for (int k = 0; k < 20; k++)
      applyStimulus(1, randInstr(), 6'($urandom), 0, 0, 0, 3'($urandom));
    applyStimulus(1, TRIG, 6'($urandom), 0, 0, 0, '0);
    trig_snap = last_snap;
    checkOutput("t2_post_busy", 64'(busy0), 64'(1));
    post_snap = '0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("t2_not_done", 64'(done0), 64'(0));
      applyStimulus(1, randInstr(), 6'($urandom), 0, 0, 0, '0);
      post_snap = last_snap;
    end
    checkOutput("t2_done",  64'(done0),  64'(1));
    checkOutput("t2_busy",  64'(busy0),  64'(0));
    checkOutput("t2_count", 64'(count0), 64'(8));
    applyStimulus(1, randInstr(), 6'($urandom), 0, 0, 0, 3'd4);
    checkOutput("t2_trig_entry", 64'(rd_data0[BASE_W-1:0]), 64'(trig_snap[BASE_W-1:0]));
    applyStimulus(0, randInstr(), 6'd0, 0, 0, 0, 3'd7);
    checkOutput("t2_last_post", 64'(rd_data0[BASE_W-1:0]), 64'(post_snap[BASE_W-1:0]));

    // IF-only capture with state cycling 0,1,2,8.
    applyStimulus(0, randInstr(), 6'd0, 1, 0, 0, '0);
    for (int k = 0; k < 16; k++)
      applyStimulus(1, randInstr(), seq[k % 4], 0, 0, 0, '0);
    checkOutput("t3_count1", 64'(count1), 64'(4));
    checkOutput("t3_count0", 64'(count0), 64'(8));
    for (int a = 0; a < 4; a++) begin
      applyStimulus(0, randInstr(), 6'd0, 0, 0, 0, 3'(a));
      checkOutput("t3_valid1", 64'(rd_valid1), 64'(1));
      checkOutput("t3_state1", 64'(rd_data1[ST_LSB +: STATE_W]), 64'(0));
    end

    // Asynchronous reset during POST, then re-arm.
    applyStimulus(0, randInstr(), 6'd0, 1, 0, 0, '0);
    applyStimulus(1, randInstr(), 6'($urandom), 0, 0, 1, '0);
    applyStimulus(1, randInstr(), 6'($urandom), 0, 0, 0, '0);
    checkOutput("t4_in_post", 64'(busy0), 64'(1));
    applyReset();
    applyStimulus(0, randInstr(), 6'd0, 1, 0, 0, '0);
    applyStimulus(1, randInstr(), 6'd0, 0, 0, 0, '0);
    first_snap = last_snap;
    applyStimulus(1, randInstr(), 6'd0, 0, 0, 0, '0);
    applyStimulus(0, randInstr(), 6'd0, 0, 0, 0, 3'd0);
    checkOutput("t4_count", 64'(count0), 64'(2));
    checkOutput("t4_first", 64'(rd_data0[BASE_W-1:0]), 64'(first_snap[BASE_W-1:0]));

    // arm and force_trig together: clear, stay ARMED.
    applyStimulus(0, randInstr(), 6'd0, 1, 0, 0, '0);
    for (int k = 0; k < 3; k++)
      applyStimulus(1, randInstr(), 6'($urandom), 0, 0, 0, '0);
    applyStimulus(1, TRIG, 6'd0, 1, 0, 1, '0);
    checkOutput("t5_count", 64'(count0), 64'(0));
    checkOutput("t5_busy",  64'(busy0),  64'(1));
    checkOutput("t5_done",  64'(done0),  64'(0));
    for (int k = 0; k < 4; k++)
      applyStimulus(1, randInstr(), 6'($urandom), 0, 0, 0, '0);
    checkOutput("t5_still_armed", 64'(busy0), 64'(1));
    checkOutput("t5_count4", 64'(count0), 64'(4));

`ifdef I281_TRACE_TIMESTAMP_EN
    applyStimulus(0, randInstr(), 6'd0, 1, 0, 0, '0);
    for (int k = 0; k < 3; k++)
      applyStimulus(0, randInstr(), 6'd0, 0, 0, 0, '0);
    applyStimulus(1, randInstr(), 6'd0, 0, 0, 0, '0);
    applyStimulus(0, randInstr(), 6'd0, 0, 0, 0, 3'd0);
    checkOutput("t6_ts", 64'(rd_data0[EW-1 -: TS_W]), 64'(3));
`endif

    // Randomised traffic: sparse arm/stop/force, occasional trigger opcode.
    for (int k = 0; k < 500; k++) begin
      logic [4:0] ri;
      logic [5:0] rs;
      if (k == 250) applyReset();
      ri = ($urandom_range(0, 5) == 0) ? TRIG : randInstr();
      rs = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom);
      applyStimulus($urandom_range(0, 3) != 0, ri, rs,
                    $urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
                    $urandom_range(0, 29) == 0, 3'($urandom));
    end

    checkOutput("sb_drain0", 64'(exp_q0.size()), 64'(0));
    checkOutput("sb_drain1", 64'(exp_q1.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
